led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator that drives an N-bit LED bank with a selectable animation (bounce, rotate, bar-fill) at a button-selected speed. It sits between the board push-button debouncers and the LED pins. Pattern advance is driven by a free-running clock prescaler whose tick rate is chosen by a saturating speed register.

## Interface
Parameters:
- N_LED, 4, number of LEDs (≥2)
- DIV_W, 25, prescaler width; the slowest tick period is 2^DIV_W cycles
- N_SPEED, 4, number of speed levels (1..DIV_W)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, synchronous, active-low; one clock; all state is in the CLK domain
- BTN_UP  in  1  single-cycle pulse from the debouncer; raise speed
- BTN_DOWN  in  1  single-cycle pulse; lower speed
- BTN_MODE  in  1  single-cycle pulse; advance animation mode
- LED  out  N_LED  LED drive, active-high
- SPEED  out  SW  current speed level; SW = max(1, clog2(N_SPEED))
- MODE  out  2  current mode: 0 BOUNCE, 1 ROTATE, 2 FILL
- TICK  out  1  one-cycle pulse on each pattern advance

## Operation
- Prescaler `cnt`, DIV_W bits, free-running and incremented every cycle; wraps to 0.
- Speed level s: the raw tick fires when `cnt[DIV_W-1-s:0]` is all ones. The tick period is 2^(DIV_W-s) cycles.
- SPEED saturates. BTN_UP at N_SPEED-1 leaves it unchanged. BTN_DOWN at 0 leaves it unchanged. BTN_UP and BTN_DOWN in the same cycle leave it unchanged.
- A speed change does not reset the prescaler. The next tick follows from the existing count.
- MODE cycles 0→1→2→0 on each BTN_MODE pulse. Encoding 3 is unreachable; if reached, it decodes as BOUNCE and the next BTN_MODE returns MODE to 0.
- Pattern state: position `p` (clog2(N_LED) bits), direction `dir`, fill level `k` (0..N_LED).
- BOUNCE: LED is one-hot at bit p. On each tick, p moves by ±1. At bit N_LED-1, dir flips to down; at bit 0, dir flips to up. The end LEDs are never shown on two consecutive ticks. Period is 2·N_LED−2 ticks.
- ROTATE: LED is one-hot at bit p. On each tick, p goes to p+1, wrapping from N_LED-1 to 0. Period is N_LED ticks.
- FILL: LED has its lower k bits set. On each tick, k goes to k+1, wrapping from N_LED to 0. Period is N_LED+1 ticks.
- Mode change: in the cycle BTN_MODE is seen, p=0, dir=up and k=0. If a tick occurs in the same cycle, it is consumed: the pattern does not advance, but TICK is still asserted.
- LED is a combinational decode of the registered MODE, p and k. No glitch-free requirement applies.

## Timing
- Reset values:
  - cnt=0, SPEED=0, MODE=0, p=0, dir=up, k=0.
  - LED=1 (bit 0 set), TICK=0.
- TICK is registered. It is high for the one cycle after `cnt` matches the speed mask.
- The pattern state updates on the same edge at which TICK goes high. LED therefore changes together with TICK rising.
- A button pulse takes effect on SPEED and MODE at the next edge, so there is 1-cycle latency.
- The first TICK after reset at speed 0 occurs 2^DIV_W cycles after RST_N is released.
- RST_N asserted mid-pattern restores all reset values on the next edge. It overrides any simultaneous button pulse or tick.

## Configuration
- LED_PAUSE_EN defined:
  - Adds input port BTN_PAUSE (1 bit, single-cycle pulse), which toggles a `paused` flag; the reset value of `paused` is 0.
  - While paused, TICK is held at 0 and the pattern is frozen.
  - The prescaler, SPEED and MODE keep operating. BTN_MODE still resets the pattern state.
- LED_PAUSE_EN undefined: the BTN_PAUSE port and `paused` logic are absent, and ticks are never suppressed.

## Structure
- Shared package `led_pkg`: mode encodings MODE_BOUNCE=0, MODE_ROTATE=1, MODE_FILL=2, and the 2-bit mode type.
- One sub-module, `led_tick_gen`. It holds the prescaler, the saturating speed register and the registered TICK output.
- The mode register, pattern state and LED decode stay in `led_pattern_gen`.

## Test plan
All scenarios use N_LED=4, DIV_W=4, N_SPEED=4.
- Reset, then hold RST_N high for 16 cycles → TICK pulses once at cycle 16. LED goes 0001→0010, and the bounce sequence continues 0100, 1000, 0100, 0010, 0001.
- Five BTN_UP pulses → SPEED saturates at 3 and TICK period is 2 cycles. Then five BTN_DOWN pulses → SPEED is 0 and TICK period is 16 cycles. BTN_UP and BTN_DOWN together → SPEED unchanged.
- BTN_MODE once, at speed 3 → MODE=1 and LED=0001. Subsequent ticks give 0010, 0100, 1000, 0001.
- BTN_MODE again → MODE=2 and LED=0000. Subsequent ticks give 0001, 0011, 0111, 1111, 0000. A third BTN_MODE → MODE=0.
- BTN_MODE in the same cycle as a tick → TICK is asserted, the pattern stays at its reset position, and the next tick advances from p=0.
- RST_N low for one cycle mid-FILL with BTN_UP pulsed simultaneously → MODE=0, SPEED=0, LED=0001. With LED_PAUSE_EN: BTN_PAUSE → no TICK for 64 cycles and LED frozen; BTN_PAUSE again → ticks resume.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encoding,
// bounce direction encoding and the mode-advance helper.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'd0,
      MODE_ROTATE = 2'd1,
      MODE_FILL   = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // The unused encoding falls back to BOUNCE on the next mode press.
   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_BOUNCE: next_mode = MODE_ROTATE;
         MODE_ROTATE: next_mode = MODE_FILL;
         default:     next_mode = MODE_BOUNCE;
      endcase
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler, saturating speed register and registered tick.
// adv is the raw (combinational) advance strobe; tick is its registered copy.
module led_tick_gen #(
   parameter int DIV_W   = 25,
   parameter int N_SPEED = 4,
   parameter int SW      = (N_SPEED > 1) ? $clog2(N_SPEED) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          up,
   input  logic          down,
   input  logic          hold,
   output logic [SW-1:0] speed,
   output logic          adv,
   output logic          tick
);

   localparam logic [SW-1:0] SPD_MAX = SW'(N_SPEED - 1);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] mask;

   // Higher speed shortens the mask, so fewer low bits must be all ones.
   always_comb begin
      mask = {DIV_W{1'b1}} >> speed;
      adv  = ((cnt & mask) == mask) && !hold;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         speed <= '0;
         tick  <= 1'b0;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= adv;
         if (up && !down && speed != SPD_MAX)
            speed <= speed + 1'b1;
         else if (down && !up && speed != '0)
            speed <= speed - 1'b1;
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// LED animation generator (bounce / rotate / bar-fill) at a selectable speed.
// Optional macro LED_PAUSE_EN adds BTN_PAUSE, which toggles a pattern freeze.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter  int N_LED   = 4,
   parameter  int DIV_W   = 25,
   parameter  int N_SPEED = 4,
   localparam int SW      = (N_SPEED > 1) ? $clog2(N_SPEED) : 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             BTN_UP,
   input  logic             BTN_DOWN,
   input  logic             BTN_MODE,
`ifdef LED_PAUSE_EN
   input  logic             BTN_PAUSE,
`endif
   output logic [N_LED-1:0] LED,
   output logic [SW-1:0]    SPEED,
   output logic [1:0]       MODE,
   output logic             TICK
);

   localparam int PW = $clog2(N_LED);
   localparam int KW = $clog2(N_LED + 1);
   localparam logic [PW-1:0] P_LAST = PW'(N_LED - 1);
   localparam logic [KW-1:0] K_FULL = KW'(N_LED);

   mode_t         mode;
   logic [PW-1:0] p, p_nxt;
   logic          dir, dir_nxt;
   logic [KW-1:0] k, k_nxt;
   logic          adv;
   logic          hold;

`ifdef LED_PAUSE_EN
   logic paused;

   always_ff @(posedge CLK) begin
      if (!RST_N)
         paused <= 1'b0;
      else if (BTN_PAUSE)
         paused <= !paused;
   end

   assign hold = paused;
`else
   assign hold = 1'b0;
`endif

   led_tick_gen #(
      .DIV_W   (DIV_W),
      .N_SPEED (N_SPEED),
      .SW      (SW)
   ) u_tick (
      .clk   (CLK),
      .rst_n (RST_N),
      .up    (BTN_UP),
      .down  (BTN_DOWN),
      .hold  (hold),
      .speed (SPEED),
      .adv   (adv),
      .tick  (TICK)
   );

   // Bounce turns around at the ends so neither end LED is shown twice in a row.
   always_comb begin
      p_nxt   = p;
      dir_nxt = dir;
      k_nxt   = k;
      case (mode)
         MODE_ROTATE: p_nxt = (p == P_LAST) ? '0 : p + 1'b1;
         MODE_FILL:   k_nxt = (k == K_FULL) ? '0 : k + 1'b1;
         default: begin
            if (p == '0)
               dir_nxt = DIR_UP;
            else if (p == P_LAST)
               dir_nxt = DIR_DOWN;
            p_nxt = (dir_nxt == DIR_UP) ? p + 1'b1 : p - 1'b1;
         end
      endcase
   end

   // A mode press restarts the pattern and swallows a coincident tick.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         mode <= MODE_BOUNCE;
         p    <= '0;
         dir  <= DIR_UP;
         k    <= '0;
      end else if (BTN_MODE) begin
         mode <= next_mode(mode);
         p    <= '0;
         dir  <= DIR_UP;
         k    <= '0;
      end else if (adv) begin
         p   <= p_nxt;
         dir <= dir_nxt;
         k   <= k_nxt;
      end
   end

   always_comb begin
      if (mode == MODE_FILL)
         LED = ~({N_LED{1'b1}} << k);
      else
         LED = {{(N_LED-1){1'b0}}, 1'b1} << p;
   end

   assign MODE = mode;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen with N_LED=4, DIV_W=4, N_SPEED=4: vector table
// of button presses and expected LED/SPEED/MODE, checked through a queue.
module tb_led_pattern_gen;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       BTN_UP = 1'b0;
   logic       BTN_DOWN = 1'b0;
   logic       BTN_MODE = 1'b0;
`ifdef LED_PAUSE_EN
   logic       BTN_PAUSE = 1'b0;
`endif
   logic [3:0] LED;
   logic [1:0] SPEED;
   logic [1:0] MODE;
   logic       TICK;

   led_pattern_gen #(
      .N_LED   (4),
      .DIV_W   (4),
      .N_SPEED (4)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .BTN_UP    (BTN_UP),
      .BTN_DOWN  (BTN_DOWN),
      .BTN_MODE  (BTN_MODE),
`ifdef LED_PAUSE_EN
      .BTN_PAUSE (BTN_PAUSE),
`endif
      .LED       (LED),
      .SPEED     (SPEED),
      .MODE      (MODE),
      .TICK      (TICK)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      logic [3:0] led;
      logic [1:0] spd;
      logic [1:0] md;
      logic       tk;
   } exp_t;

   typedef struct {
      bit         up;
      bit         dn;
      bit         md;
      logic [3:0] now_led;
      logic [1:0] now_spd;
      logic [1:0] now_mode;
      logic [3:0] tk_led;
      int         per;
   } vec_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;
   int   ncyc = 0;

   task automatic cyc();
      @(posedge CLK);
      #1;
      ncyc++;
   endtask

   task automatic push_exp(input string nm, input logic [3:0] led,
                           input logic [1:0] spd, input logic [1:0] md,
                           input logic tk);
      exp_t e;
      e.name = nm;
      e.led  = led;
      e.spd  = spd;
      e.md   = md;
      e.tk   = tk;
      sb.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      compared++;
      if (sb.size() == 0) begin
         mismatched++;
         $display("FAIL scoreboard_empty: DUT produced output with no expectation queued");
      end else begin
         e = sb.pop_front();
         if ({LED, SPEED, MODE, TICK} !== {e.led, e.spd, e.md, e.tk}) begin
            mismatched++;
            $display("FAIL %s: got LED=%b SPEED=%0d MODE=%0d TICK=%b, want LED=%b SPEED=%0d MODE=%0d TICK=%b",
                     e.name, LED, SPEED, MODE, TICK, e.led, e.spd, e.md, e.tk);
         end
      end
   endtask

   task automatic check_int(input string nm, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   // Steps until TICK is seen (bounded); ncyc then holds the edges taken.
   task automatic wait_tick(input string nm);
      int guard;
      guard = 0;
      cyc();
      while (TICK !== 1'b1 && guard < 40) begin
         cyc();
         guard++;
      end
      compared++;
      if (TICK !== 1'b1) begin
         mismatched++;
         $display("FAIL %s_timeout: got TICK=%b after %0d cycles, want TICK=1", nm, TICK, ncyc);
      end
   endtask

   task automatic count_ticks(input int n, output int seen);
      seen = 0;
      for (int c = 0; c < n; c++) begin
         cyc();
         if (TICK === 1'b1) seen++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[28];
      vec_t v;
      int   seen;

      vecs = '{
         '{0,0,0, 4'b0010, 2'd0, 2'd0, 4'b0100, 16},
         '{0,0,0, 4'b0100, 2'd0, 2'd0, 4'b1000, 16},
         '{0,0,0, 4'b1000, 2'd0, 2'd0, 4'b0100, 16},
         '{0,0,0, 4'b0100, 2'd0, 2'd0, 4'b0010, 16},
         '{0,0,0, 4'b0010, 2'd0, 2'd0, 4'b0001, 16},
         '{1,0,0, 4'b0001, 2'd1, 2'd0, 4'b0010, 8},
         '{1,0,0, 4'b0010, 2'd2, 2'd0, 4'b0100, 4},
         '{1,0,0, 4'b0100, 2'd3, 2'd0, 4'b1000, 2},
         '{1,0,0, 4'b1000, 2'd3, 2'd0, 4'b0100, 2},
         '{1,0,0, 4'b0100, 2'd3, 2'd0, 4'b0010, 2},
         '{0,0,1, 4'b0001, 2'd3, 2'd1, 4'b0010, 2},
         '{0,0,0, 4'b0010, 2'd3, 2'd1, 4'b0100, 2},
         '{0,0,0, 4'b0100, 2'd3, 2'd1, 4'b1000, 2},
         '{0,0,0, 4'b1000, 2'd3, 2'd1, 4'b0001, 2},
         '{0,0,1, 4'b0000, 2'd3, 2'd2, 4'b0001, 2},
         '{0,0,0, 4'b0001, 2'd3, 2'd2, 4'b0011, 2},
         '{0,0,0, 4'b0011, 2'd3, 2'd2, 4'b0111, 2},
         '{0,0,0, 4'b0111, 2'd3, 2'd2, 4'b1111, 2},
         '{0,0,0, 4'b1111, 2'd3, 2'd2, 4'b0000, 2},
         '{0,0,1, 4'b0001, 2'd3, 2'd0, 4'b0010, 2},
         '{0,1,0, 4'b0010, 2'd2, 2'd0, 4'b0100, 0},
         '{0,1,0, 4'b0100, 2'd1, 2'd0, 4'b1000, 0},
         '{0,1,0, 4'b1000, 2'd0, 2'd0, 4'b0100, 0},
         '{0,1,0, 4'b0100, 2'd0, 2'd0, 4'b0010, 16},
         '{0,1,0, 4'b0010, 2'd0, 2'd0, 4'b0001, 16},
         '{1,1,0, 4'b0001, 2'd0, 2'd0, 4'b0010, 16},
         '{1,0,0, 4'b0010, 2'd1, 2'd0, 4'b0100, 8},
         '{1,1,0, 4'b0100, 2'd1, 2'd0, 4'b1000, 8}
      };

      // Reset state
      push_exp("reset", 4'b0001, 2'd0, 2'd0, 1'b0);
      cyc();
      cyc();
      check_pop();
      RST_N = 1'b1;

      // First tick after release at the slowest speed
      ncyc = 0;
      push_exp("first_tick", 4'b0010, 2'd0, 2'd0, 1'b1);
      wait_tick("first_tick");
      check_pop();
      check_int("first_tick_latency", ncyc, 16);

      // Each vector starts on the edge after a tick and ends on the next tick
      for (int i = 0; i < 28; i++) begin
         v = vecs[i];
         BTN_UP   = v.up;
         BTN_DOWN = v.dn;
         BTN_MODE = v.md;
         ncyc = 0;
         push_exp($sformatf("vec%0d_now", i), v.now_led, v.now_spd, v.now_mode, 1'b0);
         cyc();
         BTN_UP   = 1'b0;
         BTN_DOWN = 1'b0;
         BTN_MODE = 1'b0;
         check_pop();
         push_exp($sformatf("vec%0d_tick", i), v.tk_led, v.now_spd, v.now_mode, 1'b1);
         wait_tick($sformatf("vec%0d", i));
         check_pop();
         if (v.per != 0)
            check_int($sformatf("vec%0d_period", i), ncyc, v.per);
      end

      // Mode press on the same edge as a tick: tick shown, pattern restarted
      count_ticks(7, seen);
      check_int("pre_coincide_ticks", seen, 0);
      BTN_MODE = 1'b1;
      push_exp("coincide", 4'b0001, 2'd1, 2'd1, 1'b1);
      cyc();
      BTN_MODE = 1'b0;
      check_pop();
      ncyc = 0;
      push_exp("after_coincide", 4'b0010, 2'd1, 2'd1, 1'b1);
      wait_tick("after_coincide");
      check_pop();
      check_int("after_coincide_period", ncyc, 8);

      // Into FILL, advance twice, then reset with a simultaneous BTN_UP
      BTN_MODE = 1'b1;
      push_exp("fill_enter", 4'b0000, 2'd1, 2'd2, 1'b0);
      cyc();
      BTN_MODE = 1'b0;
      check_pop();
      push_exp("fill_k1", 4'b0001, 2'd1, 2'd2, 1'b1);
      wait_tick("fill_k1");
      check_pop();
      push_exp("fill_k2", 4'b0011, 2'd1, 2'd2, 1'b1);
      wait_tick("fill_k2");
      check_pop();
      RST_N  = 1'b0;
      BTN_UP = 1'b1;
      push_exp("mid_reset", 4'b0001, 2'd0, 2'd0, 1'b0);
      cyc();
      RST_N  = 1'b1;
      BTN_UP = 1'b0;
      check_pop();
      ncyc = 0;
      push_exp("tick_after_reset", 4'b0010, 2'd0, 2'd0, 1'b1);
      wait_tick("tick_after_reset");
      check_pop();
      check_int("tick_after_reset_latency", ncyc, 16);

`ifdef LED_PAUSE_EN
      BTN_PAUSE = 1'b1;
      cyc();
      BTN_PAUSE = 1'b0;
      count_ticks(64, seen);
      check_int("paused_ticks", seen, 0);
      push_exp("paused_frozen", 4'b0010, 2'd0, 2'd0, 1'b0);
      check_pop();
      BTN_PAUSE = 1'b1;
      cyc();
      BTN_PAUSE = 1'b0;
      push_exp("resumed", 4'b0100, 2'd0, 2'd0, 1'b1);
      wait_tick("resumed");
      check_pop();
`endif

      check_int("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
